// File: rtl/wand_bus_tx.sv
// Wired-AND serial transmitter with bitwise arbitration.
// Drives one master's bits MSB first onto a shared wand net, reads the resolved
// value back at the end of each bit period and backs off when another master
// wins with a dominant 0. All outputs are registered.
module wand_bus_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic             line_i,
  output logic             line_o,
  output logic             busy,
  output logic             done,
  output logic             lost,
  output logic             fault
);

  localparam int unsigned IdxW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PhaseW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [IdxW-1:0]   LastIdx   = IdxW'(WIDTH - 1);
  localparam logic [PhaseW-1:0] LastPhase = PhaseW'(BIT_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [IdxW-1:0]     bit_idx_q, bit_idx_d;
  logic [PhaseW-1:0]   phase_q, phase_d;
  logic                line_q, line_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                lost_q, lost_d;
  logic                fault_q, fault_d;

  // Next-state and registered-output values; the driven bit is computed one
  // cycle ahead so line_o changes exactly at the bit boundary.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    phase_d   = phase_q;
    line_d    = line_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    lost_d    = 1'b0;
    fault_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        line_d = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          shreg_d   = data;
          bit_idx_d = '0;
          phase_d   = '0;
          line_d    = data[WIDTH-1];
          busy_d    = 1'b1;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (phase_q != LastPhase) begin
          phase_d = phase_q + 1'b1;
        end else if (line_i == line_q) begin
          if (bit_idx_q == LastIdx) begin
            done_d  = 1'b1;
            line_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            shreg_d   = shreg_q << 1;
            bit_idx_d = bit_idx_q + 1'b1;
            phase_d   = '0;
            line_d    = shreg_d[WIDTH-1];
          end
        end else begin
          // Mismatch: a recessive 1 pulled low is a loss, a dominant 0 read
          // high means the net itself is broken.
          lost_d  = line_q;
          fault_d = ~line_q;
          line_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        line_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      phase_q   <= '0;
      line_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lost_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      phase_q   <= phase_d;
      line_q    <= line_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lost_q    <= lost_d;
      fault_q   <= fault_d;
    end
  end

  assign line_o = line_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign lost   = lost_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_wand_bus_tx.sv
// Bench for wand_bus_tx: two masters share a wired-AND net; master A can have
// its read-back forced high to provoke a net fault.
module tb_wand_bus_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic [7:0] data_a, data_b;
  logic       force1;
  logic       line_a, line_b, busy_a, busy_b;
  logic       done_a, lost_a, fault_a, done_b, lost_b, fault_b;
  logic       net, a_li;

  int checks = 0;
  int errors = 0;

  assign net  = line_a & line_b;
  assign a_li = force1 ? 1'b1 : net;

  always #5 clk = ~clk;

  wand_bus_tx #(.WIDTH(8), .BIT_CYCLES(4)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .data(data_a), .line_i(a_li),
    .line_o(line_a), .busy(busy_a), .done(done_a), .lost(lost_a), .fault(fault_a)
  );

  wand_bus_tx #(.WIDTH(8), .BIT_CYCLES(4)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .data(data_b), .line_i(net),
    .line_o(line_b), .busy(busy_b), .done(done_b), .lost(lost_b), .fault(fault_b)
  );

  typedef struct {
    logic [7:0] da;
    logic [7:0] db;
    logic       use_b;
    logic       force1;
    int         ev_cyc;   // cycle after accepting edge where A's pulse lands
    logic [2:0] ev_kind;  // {done, lost, fault}
    logic [7:0] net_word; // value seen on the net at each bit's sample cycle
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch one transaction and watch 40 cycles. mid != 0 re-pulses start on A
  // with different data at that cycle, which must be ignored.
  task automatic run_vec(input string tag, input vec_t v, input int mid);
    int         ev, bdone, npulse;
    logic [2:0] kind;
    logic       ev_busy, ev_line, seq_ok, excl_ok;
    logic [7:0] netw;
    @(negedge clk);
    data_a = v.da; data_b = v.db; force1 = v.force1;
    start_a = 1'b1; start_b = v.use_b;
    ev = -1; bdone = -1; npulse = 0; kind = 3'b000; ev_busy = 1'bx; ev_line = 1'bx;
    seq_ok = 1'b1; excl_ok = 1'b1; netw = 8'h00;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin start_a = 1'b0; start_b = 1'b0; end
      if (mid != 0 && c == mid) begin start_a = 1'b1; data_a = ~v.da; end
      if (mid != 0 && c == mid + 1) start_a = 1'b0;
      if ((int'(done_a) + int'(lost_a) + int'(fault_a)) > 1) excl_ok = 1'b0;
      if ((int'(done_b) + int'(lost_b) + int'(fault_b)) > 1) excl_ok = 1'b0;
      npulse += int'(done_a) + int'(lost_a) + int'(fault_a);
      if ((done_a | lost_a | fault_a) && ev < 0) begin
        ev = c; kind = {done_a, lost_a, fault_a}; ev_busy = busy_a; ev_line = line_a;
      end
      if (ev < 0 && c < v.ev_cyc) begin
        if (line_a !== v.da[7 - (c - 1) / 4] || busy_a !== 1'b1) seq_ok = 1'b0;
      end
      if (c % 4 == 0 && c <= 32) netw[7 - (c / 4 - 1)] = net;
      if (done_b && bdone < 0) bdone = c;
    end
    chk({tag, " event_cycle"}, ev, v.ev_cyc);
    chk({tag, " event_kind"}, {29'd0, kind}, {29'd0, v.ev_kind});
    chk({tag, " pulse_count"}, npulse, 1);
    chk({tag, " idle_at_event"}, {30'd0, ev_busy, ev_line}, 32'd1);
    chk({tag, " line_sequence"}, {31'd0, seq_ok}, 32'd1);
    chk({tag, " exclusive"}, {31'd0, excl_ok}, 32'd1);
    chk({tag, " net_word"}, {24'd0, netw}, {24'd0, v.net_word});
    chk({tag, " b_done_cycle"}, bdone, v.use_b ? 33 : -1);
    force1 = 1'b0;
  endtask

  initial begin
    int c1, c2;
    logic ok;
    vecs[0] = '{8'hA5, 8'h00, 1'b0, 1'b0, 33, 3'b100, 8'hA5};
    vecs[1] = '{8'h00, 8'h00, 1'b0, 1'b0, 33, 3'b100, 8'h00};
    vecs[2] = '{8'hFF, 8'h00, 1'b0, 1'b0, 33, 3'b100, 8'hFF};
    vecs[3] = '{8'hC0, 8'h80, 1'b1, 1'b0,  9, 3'b010, 8'h80};
    vecs[4] = '{8'h7F, 8'h00, 1'b0, 1'b1,  5, 3'b001, 8'h7F};
    vecs[5] = '{8'hFF, 8'h00, 1'b0, 1'b1, 33, 3'b100, 8'hFF};
    vecs[6] = '{8'h55, 8'h54, 1'b1, 1'b0, 33, 3'b010, 8'h54};
    vecs[7] = '{8'hFE, 8'h00, 1'b0, 1'b1, 33, 3'b001, 8'hFE};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    data_a = 8'h00; data_b = 8'h00; force1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {26'd0, line_a, busy_a, done_a, lost_a, fault_a, line_b},
        {26'd0, 6'b100001});
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i], 0);

    // start re-pulsed mid-word with other data must not disturb the word
    run_vec("mid_start", vecs[0], 12);

    // reset in the middle of a word, together with a start request
    @(negedge clk);
    data_a = 8'hA5; start_a = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start_a = 1'b0;
    end
    rst = 1'b1; start_a = 1'b1;
    @(negedge clk);
    chk("rst_mid_word", {27'd0, line_a, busy_a, done_a, lost_a, fault_a}, {27'd0, 5'b10000});
    rst = 1'b0; start_a = 1'b0;
    ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (busy_a | done_a | lost_a | fault_a | ~line_a) ok = 1'b0;
    end
    chk("rst_stays_idle", {31'd0, ok}, 32'd1);
    run_vec("after_rst", vecs[0], 0);

    // back-to-back words with start held high
    @(negedge clk);
    data_a = 8'h3C; start_a = 1'b1;
    c1 = -1; c2 = -1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (done_a && c1 < 0) begin
        c1 = c; data_a = 8'hFF;
      end else if (c1 > 0 && c == c1 + 1) begin
        chk("b2b_no_gap", {30'd0, busy_a, line_a}, 32'd3);
        start_a = 1'b0;
      end else if (done_a && c2 < 0) begin
        c2 = c;
      end
    end
    chk("b2b_first_done", c1, 33);
    chk("b2b_spacing", c2 - c1, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wand_bus_tx.md
# wand_bus_tx

Serial transmitter that drives one master's contribution onto a shared wired-AND (`wand`) line and arbitrates bit by bit. It sits directly upstream of the `wand` resolution net: each master instance drives `line_o` into the net and reads the resolved value back on `line_i`. A master whose recessive 1 is overwritten by another master's dominant 0 loses arbitration and releases the line. The surviving master completes its word undisturbed.

## Interface
Parameters:
- `WIDTH`, default 8: bits per transmitted word.
- `BIT_CYCLES`, default 4: clock cycles per bit period; must be at least 2.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: reset; synchronous, active-high.
- `start`, input, 1: request to send `data`; sampled only in IDLE.
- `data`, input, `WIDTH`: word to send, MSB first; captured on accepted `start`.
- `line_i`, input, 1: resolved `wand` net value, already synchronous to `clk`.
- `line_o`, output, 1: this master's drive to the `wand` net; 1 = recessive/release, 0 = dominant.
- `busy`, output, 1: high while in SEND.
- `done`, output, 1: one-cycle pulse when all `WIDTH` bits were sent without loss.
- `lost`, output, 1: one-cycle pulse when arbitration is lost.
- `fault`, output, 1: one-cycle pulse when a driven 0 reads back as 1 (net fault).

## Operation
- State machine states: IDLE and SEND.
- Internal state:
  - `shreg[WIDTH-1:0]`
  - `bit_idx`, 0..`WIDTH-1`
  - `phase`, 0..`BIT_CYCLES-1`
- IDLE:
  - `line_o`=1, `busy`=0.
  - When `start`=1: load `shreg`←`data`, `bit_idx`←0, `phase`←0, and go to SEND.
- SEND:
  - `line_o` = `shreg[WIDTH-1]`, held constant for the whole bit period.
  - `phase` increments every cycle.
  - At `phase`==`BIT_CYCLES-1`, compare `line_i` with `line_o`:
    - Match, not last bit: shift `shreg` left by 1, `bit_idx`++, `phase`←0.
    - Match, last bit (`bit_idx`==`WIDTH-1`): pulse `done`, go to IDLE.
    - `line_o`=1 and `line_i`=0: pulse `lost`, go to IDLE. `line_o` is 1 from the next cycle.
    - `line_o`=0 and `line_i`=1: pulse `fault`, go to IDLE.
- `line_i` is ignored at every `phase` other than `BIT_CYCLES-1`. Glitches early in a bit period have no effect.
- `start` while in SEND is ignored; no queueing.
- At most one of `done`/`lost`/`fault` is high in any cycle.
- Reset:
  - `rst`=1 forces IDLE, `line_o`=1, and `busy`, `done`, `lost`, `fault` all 0. Counters and `shreg` go to 0.
  - Reset takes priority over every other event, including a mid-word SEND and a `start` in the same cycle.
- All outputs are registered.

## Timing
- `start` accepted at edge T:
  - `busy`=1 and `line_o`=`data[WIDTH-1]` from T+1.
  - Bit k is driven during cycles T+1+k·`BIT_CYCLES` .. T+(k+1)·`BIT_CYCLES`.
  - Bit k is sampled in the last of those cycles.
- Successful word:
  - `done` is high in cycle T+1+`WIDTH`·`BIT_CYCLES`; `busy` is 0 in that same cycle.
  - Total latency from accepted `start` to `done` is `WIDTH`·`BIT_CYCLES`+1 cycles.
- Loss or fault at bit k:
  - The pulse is high in cycle T+1+(k+1)·`BIT_CYCLES`.
  - `line_o`=1 and `busy`=0 in that same cycle.
- Back-to-back: `start` high in the `done`/`lost`/`fault` cycle (IDLE) is accepted. The next word's MSB is driven the following cycle, so there is no gap cycle.

## Test plan
- Loopback, `line_i`=`line_o`, `WIDTH`=8, `BIT_CYCLES`=4, `data`=0xA5:
  - `line_o` shows 1,0,1,0,0,1,0,1, each bit held 4 cycles.
  - `done` pulses exactly 33 cycles after `start`.
  - `lost`/`fault` never assert.
- Two instances A (0xC0) and B (0x80) started in the same cycle, both `line_i` = `line_o`A & `line_o`B:
  - B `done` after 33 cycles; the net carries 0x80.
  - A `lost` pulses at bit 1, cycle T+9; A `line_o`=1 thereafter.
- Fault: loopback with `line_i` forced to 1, `data`=0x7F:
  - `fault` pulses at cycle T+5.
  - `done` never asserts; `busy`=0 afterwards.
- `start` pulsed again mid-word with a different `data`:
  - Ignored; the original word completes unchanged and `done` still lands at T+33.
- `rst` asserted at cycle T+10 of a 0xA5 send:
  - Next cycle: `line_o`=1, `busy`=0, no `done`/`lost`/`fault`.
  - A fresh `start` afterwards sends its full word normally.
- Back-to-back: `start` held high with `data` 0x3C then 0xFF:
  - The second word's MSB is driven in the cycle right after the first `done`.
  - Both `done` pulses are 33 cycles apart.
